// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   inst_addr_t   : instruction address bus (31:0)
//   inst_t        : instruction word bus (31:0)
//   fetch_state_e : FETCH / DONE
//   if_id_t       : {pc, inst} payload handed to decode
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned NUM_BYTES   = 4;
  localparam int unsigned LANE_W      = 2;
  localparam int unsigned CNT_W       = 3;

  localparam logic RST_ENABLE = 1'b1;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  typedef enum logic {
    FETCH = 1'b0,
    DONE  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } if_id_t;

  // Force a redirect target onto a word boundary.
  function automatic inst_addr_t align_word(input inst_addr_t addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_byte_asm.sv
// Four-lane byte assembler: writes byte_i into lane lane_i when we_i is high
// and presents the lanes little-endian as one word.
//   clk, rst : clock, asynchronous active-high reset (clears all lanes)
//   we_i     : write enable for this cycle
//   lane_i   : target byte lane (lane k = bits 8k+7:8k)
//   byte_i   : byte to store
//   word_o   : assembled 32-bit word
module if_byte_asm
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [BYTE_W-1:0] byte_i,
  output inst_t             word_o
);

  logic [NUM_BYTES-1:0][BYTE_W-1:0] lanes_q;

  // Lane storage; untouched lanes keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      lanes_q <= '0;
    end else if (we_i) begin
      lanes_q[lane_i] <= byte_i;
    end
  end

  assign word_o = lanes_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: reads one 32-bit instruction as four byte reads,
// assembles it little-endian and offers {pc_o, inst_o} to decode with a
// valid/ready handshake. Redirects from EX abort any fetch in progress.
//   clk, rst          : clock, asynchronous active-high reset
//   mem_req_o         : byte-read request
//   mem_addr_o        : byte address of the current request
//   mem_gnt_i         : memory accepts the request this cycle
//   mem_rdata_i       : read data, valid one cycle after a grant
//   branch_flag_i     : redirect pulse
//   branch_target_i   : redirect PC (word-aligned internally)
//   id_ready_i        : decode consumes the instruction this cycle
//   inst_valid_o      : pc_o/inst_o hold a complete instruction
//   pc_o, inst_o      : PC and assembled instruction
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_rdata_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  fetch_state_e     state_q, state_d;
  inst_addr_t       pc_q, pc_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic             pending_q, pending_d;

  logic   req_c;
  logic   gnt_c;
  logic   byte_we_c;
  inst_t  word_c;
  if_id_t payload_c;

  assign req_c = (state_q == FETCH) && (req_cnt_q < CNT_W'(NUM_BYTES));
  assign gnt_c = req_c && mem_gnt_i;

  // The counters sit at zero during reset, so the request is masked by rst
  // to keep the bus quiet until reset is released.
  assign mem_req_o  = req_c && !rst;
  assign mem_addr_o = pc_q + INST_ADDR_W'(req_cnt_q);

  // A byte arriving alongside a redirect belongs to the aborted fetch.
  assign byte_we_c = pending_q && !branch_flag_i;

  if_byte_asm u_byte_asm (
    .clk    (clk),
    .rst    (rst),
    .we_i   (byte_we_c),
    .lane_i (rsp_cnt_q[LANE_W-1:0]),
    .byte_i (mem_rdata_i),
    .word_o (word_c)
  );

  // Next-state logic; redirect overrides everything, including a handshake.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    pending_d = pending_q;

    if (branch_flag_i) begin
      pc_d      = align_word(branch_target_i);
      req_cnt_d = '0;
      rsp_cnt_d = '0;
      pending_d = 1'b0;
      state_d   = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          pending_d = gnt_c;
          if (gnt_c) begin
            req_cnt_d = req_cnt_q + CNT_W'(1);
          end
          if (pending_q) begin
            rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
            if (rsp_cnt_q == CNT_W'(NUM_BYTES - 1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (id_ready_i) begin
            pc_d      = pc_q + INST_ADDR_W'(NUM_BYTES);
            req_cnt_d = '0;
            rsp_cnt_d = '0;
            pending_d = 1'b0;
            state_d   = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      pending_q <= pending_d;
    end
  end

  assign payload_c    = '{pc: pc_q, inst: word_c};
  assign inst_valid_o = (state_q == DONE);
  assign pc_o         = payload_c.pc;
  assign inst_o       = payload_c.inst;

endmodule
